aes_key_unroll: RTL and testbench



---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_sbox.sv | 33 +++
 rtl/aes_key_unroll.sv | 89 ++++++++
 tb/tb_aes_key_unroll.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, word type and the key-schedule helpers
// used by both the forward Keys block and the reverse key unroller.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0] word_t;

  typedef enum logic {
    UNROLL_IDLE = 1'b0,
    UNROLL_RUN  = 1'b1
  } unroll_state_t;

  // Round constant for round r (1..10); out-of-range indices yield zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a combinational 256-entry lookup; shared with the
// encryption datapath.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  // Entry 0 sits in the top byte so the table reads in natural row order.
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base = {~a, 3'b000};
  assign s    = TABLE[base +: 8];

endmodule

// File: rtl/aes_key_unroll.sv
// Reverse AES-128 key schedule: starting from K10, emits K10 down to K0 one
// round key per accepted transfer, deriving each previous key on the fly.
module aes_key_unroll
  import aes_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);

  unroll_state_t state, state_nxt;
  logic [127:0]  data_nxt;
  logic [3:0]    idx_nxt;

  word_t w0, w1, w2, w3;
  word_t n0, n1, n2, n3;
  word_t rot, sub;

  assign w0 = rk_data[127:96];
  assign w1 = rk_data[95:64];
  assign w2 = rk_data[63:32];
  assign w3 = rk_data[31:0];

  // Undo the forward chaining: the last three words fall out of pairwise XORs,
  // and the recovered w3 feeds the SubWord/RotWord term for w0.
  assign n3  = w3 ^ w2;
  assign n2  = w2 ^ w1;
  assign n1  = w1 ^ w0;
  assign rot = rot_word(n3);

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot[8*i +: 8]),
      .s (sub[8*i +: 8])
    );
  end

  assign n0 = w0 ^ sub ^ {rcon(rk_idx), 24'h000000};

  assign busy     = (state == UNROLL_RUN);
  assign rk_valid = (state == UNROLL_RUN);
  assign rk_last  = rk_valid && (rk_idx == 4'd0);

  always_comb begin
    state_nxt = state;
    data_nxt  = rk_data;
    idx_nxt   = rk_idx;
    case (state)
      UNROLL_IDLE: begin
        if (start) begin
          state_nxt = UNROLL_RUN;
          data_nxt  = key_in;
          idx_nxt   = 4'(AES_NR);
        end
      end
      UNROLL_RUN: begin
        if (rk_ready) begin
          if (rk_idx == 4'd0) begin
            state_nxt = UNROLL_IDLE;
          end else begin
            data_nxt = {n0, n1, n2, n3};
            idx_nxt  = rk_idx - 4'd1;
          end
        end
      end
      default: state_nxt = UNROLL_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= UNROLL_IDLE;
      rk_data <= '0;
      rk_idx  <= '0;
    end else begin
      state   <= state_nxt;
      rk_data <= data_nxt;
      rk_idx  <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_aes_key_unroll.sv
// Bench for aes_key_unroll: FIPS-197 vectors, random keys and random
// backpressure against a word-array key-schedule model with a computed S-box.
module tb_aes_key_unroll;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_ready = 1'b0;
  logic         busy, rk_valid, rk_last;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sref [256];
  logic [127:0] ref_keys [11];
  logic [127:0] cap [11];
  bit           cap_last [11];
  int           last_cycles;

  aes_key_unroll dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_calc(input int r);
    logic [7:0] c = 8'h01;
    for (int i = 1; i < r; i++) c = xt(c);
    return c;
  endfunction

  // Forward schedule w[i+4] = w[i] ^ temp(w[i+3]) solved for w[i], walking down from w[43].
  task automatic build_ref(input logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[40 + j] = k10[127 - 32*j -: 32];
    for (int i = 39; i >= 0; i--) begin
      t = w[i + 3];
      if ((i + 4) % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sref[t[31:24]], sref[t[23:16]], sref[t[15:8]], sref[t[7:0]]};
        t = t ^ {rcon_calc((i + 4) / 4), 24'h000000};
      end
      w[i] = w[i + 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_valid"}, rk_valid, 0);
    chk({tag, "_last"},  rk_last, 0);
    chk({tag, "_data"},  rk_data, 0);
    chk({tag, "_idx"},   rk_idx, 0);
  endtask

  // Called at a negedge with the block idle. poke injects ignored starts at idx5
  // and at the idx0 transfer; rst_at aborts the stream with reset at that index.
  task automatic run_stream(input logic [127:0] k10, input int ready_pct,
                            input bit poke, input int rst_at);
    int  exp_idx;
    int  cyc;
    bit  aborted;
    build_ref(k10);
    for (int r = 0; r <= 10; r++) begin cap[r] = 'x; cap_last[r] = 0; end
    key_in = k10;
    start  = 1'b1;
    @(negedge CLK);
    start   = 1'b0;
    key_in  = {$urandom, $urandom, $urandom, $urandom};
    exp_idx = 10;
    aborted = 0;
    cyc     = 0;
    while (exp_idx >= 0 && cyc < 200) begin
      chk("valid", rk_valid, 1);
      chk("busy", busy, 1);
      chk($sformatf("data_k%0d", exp_idx), rk_data, ref_keys[exp_idx]);
      chk("idx", rk_idx, 128'(exp_idx));
      chk("last", rk_last, (exp_idx == 0));
      if (rk_valid && rk_idx <= 4'd10) begin
        cap[rk_idx] = rk_data;
        cap_last[rk_idx] = rk_last;
      end
      if (rst_at == exp_idx) begin
        RST_N = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge CLK);
        chk_zero("rst_hold");
        RST_N = 1'b1;
        @(negedge CLK);
        chk_zero("post_rst");
        aborted = 1;
        break;
      end
      rk_ready = ($urandom_range(99) < ready_pct);
      start = poke && (exp_idx == 5 || (exp_idx == 0 && rk_ready));
      if (start) key_in = ~k10;
      if (rk_ready) exp_idx--;
      @(negedge CLK);
      start = 1'b0;
      cyc++;
    end
    last_cycles = cyc;
    if (!aborted) begin
      chk("stream_complete", (exp_idx < 0), 1);
      chk("end_busy", busy, 0);
      chk("end_valid", rk_valid, 0);
      chk("end_last", rk_last, 0);
      chk("end_idx", rk_idx, 0);
      chk("end_data_hold", rk_data, ref_keys[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sref[i] = sbox_calc(8'(i));

    // Power-up reset and idle behaviour.
    rk_ready = 1'b1;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST_N = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("idle_busy", busy, 0);
      chk("idle_valid", rk_valid, 0);
      chk("idle_last", rk_last, 0);
    end

    // FIPS-197 C.1, back-to-back.
    run_stream(128'h13111d7fe3944a17f307a78b4d2b30c5, 100, 0, -1);
    chk("c1_cycles", last_cycles, 11);
    chk("c1_k9", cap[9], 128'h549932d1f08557681093ed9cbe2c974e);
    chk("c1_k1", cap[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("c1_k0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("c1_k0_last", cap_last[0], 1);
    chk("c1_k1_last", cap_last[1], 0);

    // FIPS-197 A.1.
    run_stream(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 100, 0, -1);
    chk("a1_k1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1_k0", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Backpressure on C.1.
    run_stream(128'h13111d7fe3944a17f307a78b4d2b30c5, 50, 0, -1);
    chk("bp_k0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);

    // Ignored starts mid-stream and at the final transfer, then an immediate restart.
    run_stream(128'h13111d7fe3944a17f307a78b4d2b30c5, 100, 1, -1);
    chk("poke_k0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
    run_stream({$urandom, $urandom, $urandom, $urandom}, 100, 0, -1);

    // Reset mid-run, then a full stream.
    run_stream({$urandom, $urandom, $urandom, $urandom}, 100, 0, 4);
    run_stream({$urandom, $urandom, $urandom, $urandom}, 100, 0, -1);
    chk("after_rst_cycles", last_cycles, 11);

    // Random keys with random backpressure.
    for (int n = 0; n < 4; n++)
      run_stream({$urandom, $urandom, $urandom, $urandom}, 30 + 20 * n, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
